// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SERIAL_SUB_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: captures a, b, bin, then produces a - b - bin
// one bit per clock, LSB first, behind a valid/ready handshake on each side.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_nx;
    logic [N-1:0]  a_sr, b_sr, diff_sr;
    logic [CW-1:0] cnt;
    logic          br;
    logic          ovf_q;
    logic          d_bit, bo_bit;

    full_subtractor u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: defaults first so no path through this block leaves a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: if (cnt == LAST) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the shift registers are reset too, so diff reads 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_sr <= a;
                    b_sr <= b;
                    br   <= bin;
                    cnt  <= '0;
                end
                BUSY: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {d_bit, diff_sr[N-1:1]};
                    br      <= bo_bit;
                    cnt     <= cnt + 1'b1;
                    // On the MSB, br is the borrow in and bo_bit the borrow out.
                    if (cnt == LAST) ovf_q <= br ^ bo_bit;
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_sr;
    assign bout = br;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (N=8): directed vectors, backpressure,
// mid-operation reset and a reference-model regression.
module tb_serial_sub;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;
    logic       ready_dir;
    logic       rand_en;
    logic       rnd_bit = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    time  last_acc;
    bit   track_interval;

    serial_sub #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= ($urandom() & 32'd1) != 32'd0;
    assign out_ready = rand_en ? rnd_bit : ready_dir;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] r;
        int         s;
        r = {1'b0, x} - {1'b0, y} - {8'b0, c};
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        model.d  = r[7:0];
        model.bo = r[8];
        model.ov = (s > 127) || (s < -128);
    endfunction

    // Monitor: compares one scoreboard entry per result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result{diff,bout,ovf}", {diff, bout, ovf}, {e.d, e.bo, e.ov});
            end
        end
    end

    // Called at posedge+1; returns at accepting edge +1.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input exp_t e);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'd1, 64'd0);
            return;
        end
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        if (track_interval && last_acc != 0)
            check("issue_interval_ge_10", 64'(($time - last_acc) / 10 >= 10), 64'd1);
        last_acc = $time;
        #1;
        in_valid = 1'b0;
        a = 8'($urandom()); b = 8'($urandom()); bin = 1'($urandom());
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int   lat;
        exp_t e;
        rst_n = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0;
        ready_dir = 1'b0; rand_en = 1'b0; track_interval = 1'b0; last_acc = 0;

        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", {diff, bout, ovf}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic case and latency
        ready_dir = 1'b1;
        issue(8'h05, 8'h03, 1'b0, '{d: 8'h02, bo: 1'b0, ov: 1'b0});
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_cycles", 64'(lat), 64'd8);
        drain();

        // Underflow and signed overflow vectors
        issue(8'h00, 8'h01, 1'b0, '{d: 8'hFF, bo: 1'b1, ov: 1'b0});
        issue(8'h10, 8'h0F, 1'b1, '{d: 8'h00, bo: 1'b0, ov: 1'b0});
        issue(8'h7F, 8'hFF, 1'b0, '{d: 8'h80, bo: 1'b1, ov: 1'b1});
        issue(8'h00, 8'h00, 1'b1, '{d: 8'hFF, bo: 1'b1, ov: 1'b0});
        drain();

        // Backpressure with ignored in_valid pulses in BUSY and DONE
        ready_dir = 1'b0;
        issue(8'h80, 8'h01, 1'b0, '{d: 8'h7F, bo: 1'b0, ov: 1'b1});
        for (int i = 0; i < 8; i++) begin
            in_valid = i[0]; a = 8'hAA; b = 8'h55; bin = 1'b1;
            @(posedge clk); #1;
        end
        check("bp_out_valid_after_8", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~i[0];
            check("bp_hold_result", {diff, bout, ovf}, {8'h7F, 1'b0, 1'b1});
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_high", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ready_dir = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_out_valid", 64'(out_valid), 64'd0);
        check("bp_handshake_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset during compute bit 4
        issue(8'h55, 8'h22, 1'b0, model(8'h55, 8'h22, 1'b0));
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_outputs", {diff, bout, ovf}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("rst_hold_no_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h33, 8'h11, 1'b0, '{d: 8'h22, bo: 1'b0, ov: 1'b0});
        drain();

        // Back-to-back regression against the reference model
        rand_en = 1'b1;
        track_interval = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x, y;
            logic       c;
            x = 8'($urandom()); y = 8'($urandom()); c = 1'($urandom());
            e = model(x, y, c);
            issue(x, y, c, e);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
